// File: rtl/sprite_fetch.sv
// Sprite-sheet reader: walks a sprite rectangle row-major, issues ROM reads
// and streams the returned pixels out through a 2-entry valid/ready FIFO.
module sprite_fetch #(
   parameter int unsigned SHEET_W = 320,
   parameter int unsigned ADDR_W  = 17,
   parameter int unsigned PIX_W   = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [9:0]        pic_x,
   input  logic [9:0]        pic_y,
   input  logic [9:0]        spr_w,
   input  logic [9:0]        spr_h,
   output logic              rom_rd,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [PIX_W-1:0]  pix_data,
   output logic [9:0]        pix_col,
   output logic [9:0]        pix_row,
   output logic              pix_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CW = 10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DRAIN = 3'd2,
      S_EMPTY = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   typedef struct packed {
      logic [PIX_W-1:0] data;
      logic [CW-1:0]    col;
      logic [CW-1:0]    row;
      logic             last;
   } pix_t;

   state_e state_q, state_d;
   logic   busy_q, busy_d, done_q, done_d;

   logic [CW-1:0]     w_q, w_d, h_q, h_d;
   logic [CW-1:0]     col_q, col_d, row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d, rbase_q, rbase_d;
   logic              inflight_q;
   logic [CW-1:0]     mcol_q, mcol_d, mrow_q, mrow_d;
   logic              mlast_q, mlast_d;
   pix_t              fifo_q [2];
   pix_t              fifo_d [2];
   logic              wptr_q, wptr_d, rptr_q, rptr_d;
   logic [1:0]        cnt_q, cnt_d;

   logic              rd_c, pop_c, push_c, fifo_pop_c, valid_c, last_issue_c;
   pix_t              head_c;
   logic [ADDR_W-1:0] base_c;

   // State register plus registered busy/done status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (spr_w == '0 || spr_h == '0) ? S_EMPTY : S_FETCH;
         S_FETCH: if (rd_c && last_issue_c) state_d = S_DRAIN;
         S_DRAIN: if (pop_c && head_c.last) state_d = S_DONE;
         S_EMPTY: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/handshake decode; the FIFO head bypasses to the in-flight ROM word
   always_comb begin
      valid_c      = (cnt_q != 2'd0) || inflight_q;
      head_c       = (cnt_q != 2'd0) ? fifo_q[rptr_q] : '{data: rom_data, col: mcol_q, row: mrow_q, last: mlast_q};
      pop_c        = valid_c && pix_ready;
      last_issue_c = (col_q == w_q - CW'(1)) && (row_q == h_q - CW'(1));
      // occupancy (FIFO + in flight) never exceeds 2, so "occ - pop < 2" reduces to this
      rd_c         = (state_q == S_FETCH) && ((cnt_q + 2'(inflight_q) < 2'd2) || pop_c);
      busy_d       = (state_d == S_FETCH) || (state_d == S_DRAIN) || (state_d == S_EMPTY);
      done_d       = (state_d == S_DONE);
   end

   // Datapath next-state: walk counters, address generation, FIFO bookkeeping
   always_comb begin
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      rbase_d = rbase_q;
      mcol_d  = mcol_q;
      mrow_d  = mrow_q;
      mlast_d = mlast_q;
      fifo_d  = fifo_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      base_c  = ADDR_W'(32'(pic_y) * 32'(SHEET_W) + 32'(pic_x));

      if (state_q == S_IDLE && start) begin
         w_d     = spr_w;
         h_d     = spr_h;
         col_d   = '0;
         row_d   = '0;
         addr_d  = base_c;
         rbase_d = base_c;
      end

      if (rd_c) begin
         mcol_d  = col_q;
         mrow_d  = row_q;
         mlast_d = last_issue_c;
         if (col_q == w_q - CW'(1)) begin
            col_d   = '0;
            row_d   = row_q + CW'(1);
            rbase_d = rbase_q + ADDR_W'(SHEET_W);
            addr_d  = rbase_q + ADDR_W'(SHEET_W);
         end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + ADDR_W'(1);
         end
      end

      fifo_pop_c = pop_c && (cnt_q != 2'd0);
      push_c     = inflight_q && !((cnt_q == 2'd0) && pop_c);
      if (push_c) begin
         fifo_d[wptr_q] = '{data: rom_data, col: mcol_q, row: mrow_q, last: mlast_q};
         wptr_d         = ~wptr_q;
      end
      if (fifo_pop_c) rptr_d = ~rptr_q;
      cnt_d = cnt_q + 2'(push_c) - 2'(fifo_pop_c);
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q        <= '0;
         h_q        <= '0;
         col_q      <= '0;
         row_q      <= '0;
         addr_q     <= '0;
         rbase_q    <= '0;
         inflight_q <= 1'b0;
         mcol_q     <= '0;
         mrow_q     <= '0;
         mlast_q    <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         w_q        <= w_d;
         h_q        <= h_d;
         col_q      <= col_d;
         row_q      <= row_d;
         addr_q     <= addr_d;
         rbase_q    <= rbase_d;
         inflight_q <= rd_c;
         mcol_q     <= mcol_d;
         mrow_q     <= mrow_d;
         mlast_q    <= mlast_d;
         fifo_q     <= fifo_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Pixel fields are forced to zero whenever no pixel is offered
   assign rom_rd    = rd_c;
   assign rom_addr  = addr_q;
   assign pix_valid = valid_c;
   assign pix_data  = valid_c ? head_c.data : '0;
   assign pix_col   = valid_c ? head_c.col  : '0;
   assign pix_row   = valid_c ? head_c.row  : '0;
   assign pix_last  = valid_c ? head_c.last : 1'b0;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Testbench for sprite_fetch: directed and randomized sprites checked against
// a queue-based reference of the expected address and pixel streams.
module tb_sprite_fetch;

   localparam int SHEET_W = 320;
   localparam int ADDR_W  = 17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  pic_x = '0, pic_y = '0, spr_w = '0, spr_h = '0;
   logic        rom_rd;
   logic [16:0] rom_addr;
   logic [11:0] rom_data = '0;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic [11:0] pix_data;
   logic [9:0]  pix_col, pix_row;
   logic        pix_last, busy, done;

   sprite_fetch #(.SHEET_W(320), .ADDR_W(17), .PIX_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pic_x(pic_x), .pic_y(pic_y), .spr_w(spr_w), .spr_h(spr_h),
      .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_col(pix_col), .pix_row(pix_row), .pix_last(pix_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM returns the low 12 address bits one cycle after a read, junk otherwise
   always @(posedge clk) rom_data <= rom_rd ? rom_addr[11:0] : 12'($urandom);

   int checks = 0;
   int passes = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
   endtask

   // Reference streams and monitor bookkeeping
   logic [16:0] exp_addr_q[$];
   logic [32:0] exp_pix_q[$];
   bit          mon_en = 1'b0;
   bit          prev_stall;
   logic [32:0] prev_pix, mon_cur;
   int          outstanding, first_rd_cyc, first_val_cyc, last_hs_cyc, done_cyc;
   int          busy_cycles, done_cnt, acc_cnt, max_addr, start_cyc;

   task automatic load_model(input int px, input int py, input int w, input int h);
      exp_addr_q.delete();
      exp_pix_q.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            int a;
            a = ((py + r) * SHEET_W + px + c) % (1 << ADDR_W);
            exp_addr_q.push_back(17'(a));
            exp_pix_q.push_back({12'(a % 4096), 10'(c), 10'(r), (r == h - 1) && (c == w - 1)});
         end
      prev_stall = 0; outstanding = 0; first_rd_cyc = -1; first_val_cyc = -1;
      last_hs_cyc = -1; done_cyc = -1; busy_cycles = 0; done_cnt = 0; acc_cnt = 0; max_addr = 0;
   endtask

   function automatic logic ready_val(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
      return 1'($urandom_range(0, 1));
   endfunction

   // Cycle monitor: address stream, pixel stream, stall stability, occupancy, status
   always @(negedge clk) if (mon_en) begin
      mon_cur = {pix_data, pix_col, pix_row, pix_last};
      if (prev_stall) begin
         check("stall_valid", pix_valid, 1);
         check("stall_hold", mon_cur, prev_pix);
      end
      if (rom_rd) begin
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
         if (exp_addr_q.size() == 0) check("extra_rom_rd", 1, 0);
         else check("rom_addr", rom_addr, exp_addr_q.pop_front());
         outstanding++;
      end
      if (pix_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (pix_valid && pix_ready) begin
         if (exp_pix_q.size() == 0) check("extra_pixel", 1, 0);
         else check("pixel", mon_cur, exp_pix_q.pop_front());
         outstanding--;
         acc_cnt++;
         if (pix_last) last_hs_cyc = cyc;
      end
      if (rom_rd) check("occupancy_le2", outstanding <= 2, 1);
      if (busy) busy_cycles++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_low_with_done", busy, 0);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = mon_cur;
   end

   task automatic pulse_start(input int px, input int py, input int w, input int h, input logic rdy);
      @(posedge clk); #1;
      start = 1'b1; pic_x = 10'(px); pic_y = 10'(py); spr_w = 10'(w); spr_h = 10'(h);
      pix_ready = rdy;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      pic_x = 10'($urandom); pic_y = 10'($urandom); spr_w = 10'($urandom); spr_h = 10'($urandom);
   endtask

   task automatic run_sprite(input int px, input int py, input int w, input int h,
                             input int mode, input bit inject);
      int k, limit;
      load_model(px, py, w, h);
      mon_en = 1'b1;
      pulse_start(px, py, w, h, ready_val(mode, 0));
      k = 1;
      limit = 4 * w * h + 50;
      while (done_cnt == 0 && k < limit) begin
         pix_ready = ready_val(mode, k);
         start = inject && (k == 10);
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      pix_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      mon_en = 1'b0;
      check("done_once", done_cnt, 1);
      check("addr_stream_drained", exp_addr_q.size(), 0);
      check("pix_stream_drained", exp_pix_q.size(), 0);
      check("busy_idle_after", busy, 0);
      check("busy_span", busy_cycles, done_cyc - start_cyc - 1);
      if (w == 0 || h == 0) begin
         check("empty_no_rd", first_rd_cyc, -1);
         check("empty_no_valid", first_val_cyc, -1);
         check("empty_done_lat", done_cyc, start_cyc + 2);
         check("empty_busy_1cyc", busy_cycles, 1);
      end else begin
         check("rd_latency", first_rd_cyc, start_cyc + 1);
         check("valid_latency", first_val_cyc, start_cyc + 2);
         check("done_after_last", done_cyc, last_hs_cyc + 1);
         if (mode == 0) check("throughput", last_hs_cyc, start_cyc + 1 + w * h);
      end
   endtask

   initial begin
      int k;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {rom_rd, rom_addr, pix_valid, pix_data, pix_col, pix_row, pix_last, busy, done}, 0);
      rst_n = 1'b1;

      // T1 basic 2x2 with ready held high
      run_sprite(0, 30, 2, 2, 0, 0);
      // T2 single row with a 1,0,0,1 ready pattern
      run_sprite(10, 5, 4, 1, 1, 0);
      // T3 zero-width sprite
      run_sprite(7, 7, 0, 5, 0, 0);
      // T4 large sprite, extra start while busy
      run_sprite(290, 190, 30, 30, 0, 1);
      check("t4_max_addr", max_addr, 70399);

      // T5 reset in the middle of a 4x4 sprite
      load_model(0, 0, 4, 4);
      mon_en = 1'b1;
      pulse_start(0, 0, 4, 4, 1'b1);
      k = 0;
      while (acc_cnt < 4 && k < 100) begin @(posedge clk); #1; k++; end
      check("t5_reached_pixel5", acc_cnt >= 4, 1);
      mon_en = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("t5_async_reset", {rom_rd, rom_addr, pix_valid, pix_data, pix_col, pix_row, pix_last, busy, done}, 0);
      repeat (2) begin
         @(negedge clk);
         check("t5_no_done_in_reset", {done, busy, pix_valid, rom_rd}, 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      run_sprite(20, 40, 4, 4, 0, 0);

      // T6 address wrap past 2^17
      run_sprite(319, 409, 2, 1, 0, 0);

      // randomized sprites with random backpressure
      repeat (12)
         run_sprite(int'($urandom_range(0, 319)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 2, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
